// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive/transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int unsigned MAX_DATA_BITS = 9;

    function automatic int unsigned tick_div(
        input int unsigned sys_clock,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        return sys_clock / (baud_rate * oversample);
    endfunction

    // High when data word plus received parity bit disagree with the selected parity
    function automatic logic parity_bad(
        input logic [MAX_DATA_BITS-1:0] word,
        input logic                     par_bit,
        input logic                     odd
    );
        return (^word) ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Prescaler producing a one-cycle os_tick at OVERSAMPLE times the line rate.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK  = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int unsigned TICK_DIV = tick_div(SYS_CLOCK, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_baud_gen: SYS_CLOCK too low for BAUD_RATE*OVERSAMPLE");
    end

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt     <= '0;
            os_tick <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 5-9 data bits, optional parity, 1-2 stop bits,
// word and status held for the consumer behind a valid/ack handshake.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK  = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_input,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_output,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned OS_LAST = OVERSAMPLE - 1;
    localparam int unsigned OS_MID  = OVERSAMPLE / 2 - 1;

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    logic os_tick;

    uart_baud_gen #(
        .SYS_CLOCK (SYS_CLOCK),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .os_tick(os_tick)
    );

    // Two-stage synchroniser; idles high like the line
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_input;
            rx_sync <= rx_meta;
        end
    end

    state_t               state;
    logic [OS_W-1:0]      os_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 pub_pending;
    logic                 os_last_c;

    assign os_last_c = (os_cnt == OS_W'(OS_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            os_cnt       <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            pub_pending  <= 1'b0;
            data_output  <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (data_ack && data_valid) begin
                data_valid   <= 1'b0;
                parity_error <= 1'b0;
                frame_error  <= 1'b0;
                overrun      <= 1'b0;
            end

            // Publishing overrides a coincident ack; the acked word is simply replaced
            if (pub_pending) begin
                pub_pending  <= 1'b0;
                data_output  <= shreg;
                parity_error <= perr;
                frame_error  <= ferr;
                data_valid   <= 1'b1;
                overrun      <= data_valid && !data_ack;
                state        <= ferr ? BREAK : IDLE;
                busy         <= ferr;
            end else if (os_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_sync) begin
                            state  <= START;
                            os_cnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (os_cnt == OS_W'(OS_MID)) begin
                            if (rx_sync) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                                perr    <= 1'b0;
                                ferr    <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (os_last_c) begin
                            os_cnt <= '0;
                            shreg  <= {rx_sync, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (os_last_c) begin
                            os_cnt <= '0;
                            perr   <= parity_bad(MAX_DATA_BITS'(shreg), rx_sync, 1'(PARITY_ODD));
                            state  <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (os_last_c) begin
                            os_cnt <= '0;
                            ferr   <= ferr | ~rx_sync;
                            if (bit_cnt == 4'(STOP_BITS - 1)) begin
                                pub_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_sync) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 8E1, 7N2) on one shared line.
module tb_uart_rx_os;

    localparam int unsigned SYS_CLOCK = 1536000;
    localparam int unsigned BAUD      = 9600;
    localparam int unsigned OS        = 16;
    localparam int          BIT       = 160;
    localparam int          NV        = 11;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ack [3];
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;
    logic       valid [3];
    logic       perr_o [3];
    logic       ferr_o [3];
    logic       ovr [3];
    logic       busy [3];
    int         errors = 0;
    int         checks = 0;
    vec_t       vecs [NV];

    always #5 clk = ~clk;

    uart_rx_os #(.SYS_CLOCK(SYS_CLOCK), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .rx_input(rx), .data_ack(ack[0]), .data_output(d0),
        .data_valid(valid[0]), .parity_error(perr_o[0]), .frame_error(ferr_o[0]),
        .overrun(ovr[0]), .busy(busy[0]));

    uart_rx_os #(.SYS_CLOCK(SYS_CLOCK), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .rx_input(rx), .data_ack(ack[1]), .data_output(d1),
        .data_valid(valid[1]), .parity_error(perr_o[1]), .frame_error(ferr_o[1]),
        .overrun(ovr[1]), .busy(busy[1]));

    uart_rx_os #(.SYS_CLOCK(SYS_CLOCK), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .rx_input(rx), .data_ack(ack[2]), .data_output(d2),
        .data_valid(valid[2]), .parity_error(perr_o[2]), .frame_error(ferr_o[2]),
        .overrun(ovr[2]), .busy(busy[2]));

    function automatic logic [8:0] dout(input int i);
        case (i)
            0:       return 9'(d0);
            1:       return 9'(d1);
            default: return 9'(d2);
        endcase
    endfunction

    function automatic int nbits(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int nstops(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        tick(BIT);
    endtask

    task automatic send(input int dut, input logic [8:0] data, input logic par, input logic [1:0] stops);
        line_bit(1'b0);
        for (int i = 0; i < nbits(dut); i++) line_bit(data[i]);
        if (dut == 1) line_bit(par);
        for (int i = 0; i < nstops(dut); i++) line_bit(stops[i]);
    endtask

    task automatic ack_pulse(input int i);
        ack[i] = 1'b1;
        tick(1);
        ack[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    // Returns just after the clock edge on which busy rose (bounded)
    task automatic wait_busy(input int dut, input string name);
        for (int i = 0; i < 400; i++) begin
            if (busy[dut]) break;
            tick(1);
        end
        chk(name, 32'(busy[dut]), 32'd1);
    endtask

    task automatic chk_word(input string name, input int dut, input logic [8:0] exp_d,
                            input logic exp_p, input logic exp_f, input logic exp_o);
        chk({name, " valid"}, 32'(valid[dut]), 32'd1);
        chk({name, " data"},  32'(dout(dut)),  32'(exp_d));
        chk({name, " perr"},  32'(perr_o[dut]), 32'(exp_p));
        chk({name, " ferr"},  32'(ferr_o[dut]), 32'(exp_f));
        chk({name, " ovr"},   32'(ovr[dut]),   32'(exp_o));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vecs[3]  = '{0, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b1};
        vecs[4]  = '{1, 9'h037, 1'b0, 2'b11, 9'h037, 1'b1, 1'b0};
        vecs[5]  = '{1, 9'h037, 1'b1, 2'b11, 9'h037, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[7]  = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
        vecs[8]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        vecs[9]  = '{2, 9'h07F, 1'b0, 2'b01, 9'h07F, 1'b0, 1'b1};
        vecs[10] = '{2, 9'h02A, 1'b0, 2'b10, 9'h02A, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) ack[i] = 1'b0;
        do_reset();

        // Reset state
        chk("rst valid", 32'(valid[0]), 32'd0);
        chk("rst data",  32'(dout(0)),  32'd0);
        chk("rst perr",  32'(perr_o[0]), 32'd0);
        chk("rst ferr",  32'(ferr_o[0]), 32'd0);
        chk("rst ovr",   32'(ovr[0]),   32'd0);
        chk("rst busy",  32'(busy[0]),  32'd0);
        chk("rst valid1", 32'(valid[1]), 32'd0);
        chk("rst busy2",  32'(busy[2]),  32'd0);
        ack_pulse(0);
        chk("idle ack valid", 32'(valid[0]), 32'd0);
        chk("idle ack ovr",   32'(ovr[0]),   32'd0);

        // 8N1 0xA5 with exact publish latency measured from the start detection
        fork
            send(0, 9'h0A5, 1'b0, 2'b11);
            begin
                wait_busy(0, "t1 busy rise");
                tick(1520);
                chk("t1 valid before publish", 32'(valid[0]), 32'd0);
                tick(1);
                chk("t1 valid at publish", 32'(valid[0]), 32'd1);
            end
        join
        tick(BIT);
        chk_word("t1", 0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        ack_pulse(0);
        chk("t1 valid after ack", 32'(valid[0]), 32'd0);

        // False start: 40 clk low glitch
        do_reset();
        rx = 1'b0;
        tick(40);
        chk("t2 busy during glitch", 32'(busy[0]), 32'd1);
        rx = 1'b1;
        tick(100);
        chk("t2 busy after midpoint", 32'(busy[0]), 32'd0);
        tick(12 * BIT);
        chk("t2 no word", 32'(valid[0]), 32'd0);

        // Table-driven frames across the three configurations
        do_reset();
        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < 3; i++) ack[i] = 1'b1;
            tick(1);
            for (int i = 0; i < 3; i++) ack[i] = 1'b0;
            send(vecs[k].dut, vecs[k].data, vecs[k].par, vecs[k].stops);
            rx = 1'b1;
            tick(3 * BIT);
            chk_word($sformatf("vec%0d", k), vecs[k].dut, vecs[k].exp_data,
                     vecs[k].exp_perr, vecs[k].exp_ferr, 1'b0);
            ack_pulse(vecs[k].dut);
            chk($sformatf("vec%0d valid after ack", k), 32'(valid[vecs[k].dut]), 32'd0);
        end

        // Held-low line after a bad stop bit yields a single frame_error word
        do_reset();
        send(0, 9'h05A, 1'b0, 2'b00);
        tick(20 * BIT);
        chk_word("t4 break", 0, 9'h05A, 1'b0, 1'b1, 1'b0);
        chk("t4 busy in break", 32'(busy[0]), 32'd1);
        rx = 1'b1;
        tick(3 * BIT);
        chk("t4 busy after release", 32'(busy[0]), 32'd0);
        ack_pulse(0);
        send(0, 9'h05A, 1'b0, 2'b11);
        tick(2 * BIT);
        chk_word("t4 clean", 0, 9'h05A, 1'b0, 1'b0, 1'b0);

        // Overrun, then ack coinciding with publish
        do_reset();
        send(0, 9'h011, 1'b0, 2'b11);
        send(0, 9'h022, 1'b0, 2'b11);
        tick(2 * BIT);
        chk_word("t5 overrun", 0, 9'h022, 1'b0, 1'b0, 1'b1);
        ack_pulse(0);
        chk("t5 valid after ack", 32'(valid[0]), 32'd0);
        chk("t5 ovr after ack",   32'(ovr[0]),   32'd0);
        send(0, 9'h033, 1'b0, 2'b11);
        tick(2 * BIT);
        chk("t5 held 0x33", 32'(dout(0)), 32'h33);
        fork
            send(0, 9'h044, 1'b0, 2'b11);
            begin
                wait_busy(0, "t5 busy rise");
                tick(1520);
                chk("t5 old word still held", 32'(dout(0)), 32'h33);
                ack[0] = 1'b1;
                tick(1);
                ack[0] = 1'b0;
                chk_word("t5 ack+publish", 0, 9'h044, 1'b0, 1'b0, 1'b0);
            end
        join
        tick(2 * BIT);
        chk("t5 word kept", 32'(valid[0]), 32'd1);

        // 7N2: reset in the middle of data bit 4
        do_reset();
        send(2, 9'h055, 1'b0, 2'b11);
        tick(2 * BIT);
        chk("t6 held word", 32'(valid[2]), 32'd1);
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'(9'h043 >> i));
        rx = 1'b0;
        tick(BIT / 2);
        chk("t6 busy mid frame", 32'(busy[2]), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("t6 rst valid", 32'(valid[2]), 32'd0);
        chk("t6 rst data",  32'(dout(2)),  32'd0);
        chk("t6 rst perr",  32'(perr_o[2]), 32'd0);
        chk("t6 rst ferr",  32'(ferr_o[2]), 32'd0);
        chk("t6 rst ovr",   32'(ovr[2]),   32'd0);
        chk("t6 rst busy",  32'(busy[2]),  32'd0);
        reset = 1'b0;
        rx    = 1'b1;
        tick(3 * BIT);
        chk("t6 no partial word", 32'(valid[2]), 32'd0);
        send(2, 9'h043, 1'b0, 2'b11);
        tick(2 * BIT);
        chk_word("t6 after reset", 2, 9'h043, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
